// File: rtl/hpdcache_mem_read_responder_if.sv
// Request/response bus between an HPDcache memory master and the read responder.
// Signal suffixes (_i/_o) are from the responder's point of view.
interface hpdcache_mem_read_responder_if #(
    parameter int unsigned MemAddrWidth = 56,
    parameter int unsigned MemIdWidth   = 6,
    parameter int unsigned MemDataWidth = 512
) ();
    logic                    mem_req_valid_i;
    logic                    mem_req_ready_o;
    logic [MemAddrWidth-1:0] mem_req_addr_i;
    logic [7:0]              mem_req_len_i;
    logic [2:0]              mem_req_size_i;
    logic [MemIdWidth-1:0]   mem_req_id_i;
    logic [1:0]              mem_req_command_i;

    logic                    mem_resp_r_valid_o;
    logic                    mem_resp_r_ready_i;
    logic [1:0]              mem_resp_r_error_o;
    logic [MemIdWidth-1:0]   mem_resp_r_id_o;
    logic [MemDataWidth-1:0] mem_resp_r_data_o;
    logic                    mem_resp_r_last_o;

    modport slave (
        input  mem_req_valid_i, mem_req_addr_i, mem_req_len_i, mem_req_size_i,
               mem_req_id_i, mem_req_command_i, mem_resp_r_ready_i,
        output mem_req_ready_o, mem_resp_r_valid_o, mem_resp_r_error_o,
               mem_resp_r_id_o, mem_resp_r_data_o, mem_resp_r_last_o
    );

    modport master (
        output mem_req_valid_i, mem_req_addr_i, mem_req_len_i, mem_req_size_i,
               mem_req_id_i, mem_req_command_i, mem_resp_r_ready_i,
        input  mem_req_ready_o, mem_resp_r_valid_o, mem_resp_r_error_o,
               mem_resp_r_id_o, mem_resp_r_data_o, mem_resp_r_last_o
    );
endinterface

// File: rtl/hpdcache_mem_read_responder.sv
// Memory-model read responder: queues burst read requests and returns beats from a backing array.
// Optional macro HPDCACHE_MEM_READ_RESPONDER_DELAY_EN adds cfg_delay_i and a WAIT state before each fetch.
module hpdcache_mem_read_responder #(
    parameter int unsigned MemAddrWidth = 56,
    parameter int unsigned MemIdWidth   = 6,
    parameter int unsigned MemDataWidth = 512,
    parameter int unsigned MemWords     = 256,
    parameter int unsigned ReqFifoDepth = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    hpdcache_mem_read_responder_if.slave mem_if,
    input  logic                        init_we_i,
    input  logic [$clog2(MemWords)-1:0] init_idx_i,
    input  logic [MemDataWidth-1:0]     init_data_i
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
    ,
    input  logic [7:0]                  cfg_delay_i
`endif
);
    localparam int unsigned OffW = $clog2(MemDataWidth / 8);
    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
    localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);

    typedef struct packed {
        logic [IdxW-1:0]       idx;
        logic [7:0]            len;
        logic [MemIdWidth-1:0] id;
        logic                  err;
    } req_t;

`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FETCH, ST_SEND} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND} state_e;
`endif

    logic [MemDataWidth-1:0] r_mem [MemWords];
    req_t                    r_fifo [ReqFifoDepth];
    logic [PtrW-1:0]         r_wr_ptr;
    logic [PtrW-1:0]         r_rd_ptr;
    logic [CntW-1:0]         r_count;

    state_e                  r_state;
    logic [IdxW-1:0]         r_idx;
    logic [7:0]              r_len;
    logic [7:0]              r_beat_cnt;
    logic                    r_err;
    logic                    r_valid;
    logic                    r_last;
    logic [1:0]              r_error;
    logic [MemIdWidth-1:0]   r_id;
    logic [MemDataWidth-1:0] r_data;
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
    logic [7:0]              r_delay_cnt;
`endif

    logic w_ready;
    logic w_push;
    logic w_pop;
    req_t w_new_req;
    req_t w_head;
    logic w_unused;

    assign w_ready   = (r_count != CntW'(ReqFifoDepth));
    assign w_push    = mem_if.mem_req_valid_i && w_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_new_req.idx = mem_if.mem_req_addr_i[OffW +: IdxW];
    assign w_new_req.len = mem_if.mem_req_len_i;
    assign w_new_req.id  = mem_if.mem_req_id_i;
    assign w_new_req.err = (mem_if.mem_req_command_i != 2'b00);

    // Byte offset, aliased upper address bits and size carry no meaning for this model.
    assign w_unused = ^{mem_if.mem_req_size_i,
                        mem_if.mem_req_addr_i[OffW-1:0],
                        mem_if.mem_req_addr_i[MemAddrWidth-1:OffW+IdxW]};

    assign mem_if.mem_req_ready_o    = w_ready;
    assign mem_if.mem_resp_r_valid_o = r_valid;
    assign mem_if.mem_resp_r_last_o  = r_last;
    assign mem_if.mem_resp_r_error_o = r_error;
    assign mem_if.mem_resp_r_id_o    = r_id;
    assign mem_if.mem_resp_r_data_o  = r_data;

    // Backing array: backdoor write port only, never reset.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            r_mem[init_idx_i] <= init_data_i;
        end
    end

    // Request FIFO storage.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_new_req;
        end
    end

    // FIFO pointers, burst FSM and registered response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_error     <= 2'b00;
            r_id        <= '0;
            r_data      <= '0;
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
            r_delay_cnt <= '0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(ReqFifoDepth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(ReqFifoDepth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_idx      <= w_head.idx;
                        r_len      <= w_head.len;
                        r_id       <= w_head.id;
                        r_err      <= w_head.err;
                        r_beat_cnt <= '0;
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
                        if (cfg_delay_i != 8'd0) begin
                            r_delay_cnt <= cfg_delay_i;
                            r_state     <= ST_WAIT;
                        end else begin
                            r_state <= ST_FETCH;
                        end
`else
                        r_state    <= ST_FETCH;
`endif
                    end
                end
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
                ST_WAIT: begin
                    r_delay_cnt <= r_delay_cnt - 8'd1;
                    if (r_delay_cnt == 8'd1) begin
                        r_state <= ST_FETCH;
                    end
                end
`endif
                ST_FETCH: begin
                    // Unsupported commands terminate the burst with a single zero-data error beat.
                    r_valid <= 1'b1;
                    r_data  <= r_err ? '0 : r_mem[r_idx];
                    r_error <= r_err ? 2'b10 : 2'b00;
                    r_last  <= r_err || (r_beat_cnt == r_len);
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (mem_if.mem_resp_r_ready_i) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                            r_idx      <= r_idx + IdxW'(1);
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Directed bench for hpdcache_mem_read_responder: vector table plus hand-written corner sequences.
module tb_hpdcache_mem_read_responder;
    localparam int unsigned AW = 56;
    localparam int unsigned IW = 6;
    localparam int unsigned DW = 512;
    localparam int unsigned MW = 256;
    localparam int unsigned FD = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
        logic [1:0]    cmd;
        int            beats;
        logic [7:0]    idx;
        logic [1:0]    err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_we;
    logic [7:0]    init_idx;
    logic [DW-1:0] init_data;
    logic [7:0]    cfg_delay;

    logic [DW-1:0] model [MW];
    vec_t          vecs [7];
    int            n_checks = 0;
    int            n_errs   = 0;

    always #5 clk = ~clk;

    hpdcache_mem_read_responder_if #(.MemAddrWidth(AW), .MemIdWidth(IW), .MemDataWidth(DW)) bus ();

    hpdcache_mem_read_responder #(
        .MemAddrWidth(AW), .MemIdWidth(IW), .MemDataWidth(DW),
        .MemWords(MW), .ReqFifoDepth(FD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mem_if     (bus),
        .init_we_i  (init_we),
        .init_idx_i (init_idx),
        .init_data_i(init_data)
`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
        ,
        .cfg_delay_i(cfg_delay)
`endif
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        if (i == 5) return {64{8'hA5}};
        w = {24'hC0FFEE, 8'(i)};
        return {16{w}};
    endfunction

    // Returns at #1 after the accepting edge.
    task automatic push_req(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IW-1:0] id, input logic [1:0] cmd);
        bit ok = 1'b0;
        bus.mem_req_valid_i   = 1'b1;
        bus.mem_req_addr_i    = addr;
        bus.mem_req_len_i     = len;
        bus.mem_req_size_i    = 3'd6;
        bus.mem_req_id_i      = id;
        bus.mem_req_command_i = cmd;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = bus.mem_req_ready_o;
            tick();
        end
        bus.mem_req_valid_i = 1'b0;
        chk("req_accept", 512'(ok), 512'(1));
    endtask

    task automatic wait_valid(output bit seen);
        seen = bus.mem_resp_r_valid_o;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            seen = bus.mem_resp_r_valid_o;
        end
    endtask

    task automatic run_vector(input int vi, input vec_t v, input int exp_lat);
        int         lat;
        bit         seen;
        logic [7:0] bi;
        bus.mem_resp_r_ready_i = 1'b1;
        push_req(v.addr, v.len, v.id, v.cmd);
        lat = 0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            lat++;
            seen = bus.mem_resp_r_valid_o;
        end
        chk($sformatf("v%0d_latency", vi), 512'(lat), 512'(exp_lat));
        for (int b = 0; b < v.beats; b++) begin
            if (b > 0) wait_valid(seen);
            chk($sformatf("v%0d_b%0d_valid", vi, b), 512'(seen), 512'(1));
            bi = v.idx + 8'(b);
            chk($sformatf("v%0d_b%0d_id", vi, b), 512'(bus.mem_resp_r_id_o), 512'(v.id));
            chk($sformatf("v%0d_b%0d_err", vi, b), 512'(bus.mem_resp_r_error_o), 512'(v.err));
            chk($sformatf("v%0d_b%0d_last", vi, b), 512'(bus.mem_resp_r_last_o),
                512'(b == v.beats - 1));
            chk($sformatf("v%0d_b%0d_data", vi, b), bus.mem_resp_r_data_o,
                (v.err != 2'b00) ? '0 : model[bi]);
            tick();
        end
        tick();
        tick();
        chk($sformatf("v%0d_no_extra", vi), 512'(bus.mem_resp_r_valid_o), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] exp_id   [6];
        logic [7:0]    exp_idx  [6];
        logic          exp_last [6];
        logic [DW-1:0] h_data;
        logic [IW-1:0] h_id;
        logic          h_last;
        logic [1:0]    h_err;
        logic [DW-1:0] old60;
        bit            prev_stall;
        bit            seen;
        int            got;
        int            vcount;

        vecs[0] = '{56'h140, 8'd0, 6'd3, 2'b00, 1, 8'd5, 2'b00};
        vecs[1] = '{56'h3F80, 8'd3, 6'd7, 2'b00, 4, 8'd254, 2'b00};
        vecs[2] = '{56'h0, 8'd7, 6'd9, 2'b01, 1, 8'd0, 2'b10};
        vecs[3] = '{56'h0000_0100_0000_02A5, 8'd1, 6'h3F, 2'b00, 2, 8'd10, 2'b00};
        vecs[4] = '{56'h40, 8'd0, 6'd1, 2'b11, 1, 8'd1, 2'b10};
        vecs[5] = '{56'h0, 8'd255, 6'd2, 2'b00, 256, 8'd0, 2'b00};
        vecs[6] = '{56'hFFC0, 8'd1, 6'd5, 2'b00, 2, 8'd255, 2'b00};

        rst = 1'b1;
        init_we = 1'b0;
        init_idx = '0;
        init_data = '0;
        cfg_delay = 8'd0;
        bus.mem_req_valid_i = 1'b0;
        bus.mem_req_addr_i = '0;
        bus.mem_req_len_i = '0;
        bus.mem_req_size_i = '0;
        bus.mem_req_id_i = '0;
        bus.mem_req_command_i = '0;
        bus.mem_resp_r_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", 512'(bus.mem_resp_r_valid_o), 512'(0));
        chk("rst_last", 512'(bus.mem_resp_r_last_o), 512'(0));
        chk("rst_err", 512'(bus.mem_resp_r_error_o), 512'(0));
        chk("rst_id", 512'(bus.mem_resp_r_id_o), 512'(0));
        chk("rst_data", bus.mem_resp_r_data_o, '0);
        chk("rst_ready", 512'(bus.mem_req_ready_o), 512'(1));
        rst = 1'b0;

        for (int i = 0; i < MW; i++) begin
            model[i] = pat(i);
            init_we = 1'b1;
            init_idx = 8'(i);
            init_data = pat(i);
            tick();
        end
        init_we = 1'b0;
        tick();

        for (int vi = 0; vi < 7; vi++) run_vector(vi, vecs[vi], 2);

        // Backdoor write to idx 60 lands on the same edge as the FETCH read.
        old60 = model[60];
        bus.mem_resp_r_ready_i = 1'b1;
        push_req(56'(60 * 64), 8'd0, 6'd11, 2'b00);
        tick();
        init_we = 1'b1;
        init_idx = 8'd60;
        init_data = {8{64'hDEAD_BEEF_0BAD_F00D}};
        tick();
        init_we = 1'b0;
        chk("coll_valid", 512'(bus.mem_resp_r_valid_o), 512'(1));
        chk("coll_old_data", bus.mem_resp_r_data_o, old60);
        model[60] = {8{64'hDEAD_BEEF_0BAD_F00D}};
        tick();
        tick();
        run_vector(7, '{56'(60 * 64), 8'd0, 6'd12, 2'b00, 1, 8'd60, 2'b00}, 2);

        // Three queued requests, then drain under random backpressure.
        bus.mem_resp_r_ready_i = 1'b0;
        push_req(56'(20 * 64), 8'd1, 6'd1, 2'b00);
        push_req(56'(30 * 64), 8'd0, 6'd2, 2'b00);
        push_req(56'(40 * 64), 8'd2, 6'd3, 2'b00);
        chk("bp_ready_full", 512'(bus.mem_req_ready_o), 512'(0));
        exp_id   = '{6'd1, 6'd1, 6'd2, 6'd3, 6'd3, 6'd3};
        exp_idx  = '{8'd20, 8'd21, 8'd30, 8'd40, 8'd41, 8'd42};
        exp_last = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        got = 0;
        prev_stall = 1'b0;
        h_data = '0; h_id = '0; h_last = 1'b0; h_err = 2'b00;
        for (int t = 0; t < 400 && got < 6; t++) begin
            bus.mem_resp_r_ready_i = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                chk("bp_stable_valid", 512'(bus.mem_resp_r_valid_o), 512'(1));
                chk("bp_stable_data", bus.mem_resp_r_data_o, h_data);
                chk("bp_stable_id", 512'(bus.mem_resp_r_id_o), 512'(h_id));
                chk("bp_stable_last", 512'(bus.mem_resp_r_last_o), 512'(h_last));
                chk("bp_stable_err", 512'(bus.mem_resp_r_error_o), 512'(h_err));
            end
            if (bus.mem_resp_r_valid_o) begin
                if (bus.mem_resp_r_ready_i) begin
                    chk($sformatf("bp_b%0d_id", got), 512'(bus.mem_resp_r_id_o), 512'(exp_id[got]));
                    chk($sformatf("bp_b%0d_data", got), bus.mem_resp_r_data_o, model[exp_idx[got]]);
                    chk($sformatf("bp_b%0d_last", got), 512'(bus.mem_resp_r_last_o), 512'(exp_last[got]));
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    h_data = bus.mem_resp_r_data_o;
                    h_id   = bus.mem_resp_r_id_o;
                    h_last = bus.mem_resp_r_last_o;
                    h_err  = bus.mem_resp_r_error_o;
                end
            end else begin
                prev_stall = 1'b0;
            end
            tick();
        end
        chk("bp_beats", 512'(got), 512'(6));
        bus.mem_resp_r_ready_i = 1'b1;
        tick();
        tick();

`ifdef HPDCACHE_MEM_READ_RESPONDER_DELAY_EN
        cfg_delay = 8'd4;
        run_vector(8, vecs[0], 6);
        cfg_delay = 8'd0;
        run_vector(9, vecs[0], 2);
`endif

        // Reset during beat 2 of an 8-beat burst with a second request queued.
        bus.mem_resp_r_ready_i = 1'b1;
        push_req(56'(50 * 64), 8'd7, 6'd4, 2'b00);
        push_req(56'(70 * 64), 8'd0, 6'd5, 2'b00);
        wait_valid(seen);
        chk("mid_beat1", 512'(seen), 512'(1));
        tick();
        wait_valid(seen);
        chk("mid_beat2", 512'(seen), 512'(1));
        chk("mid_beat2_data", bus.mem_resp_r_data_o, model[51]);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 512'(bus.mem_resp_r_valid_o), 512'(0));
        chk("mid_rst_data", bus.mem_resp_r_data_o, '0);
        chk("mid_rst_id", 512'(bus.mem_resp_r_id_o), 512'(0));
        tick();
        tick();
        rst = 1'b0;
        vcount = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.mem_resp_r_valid_o) vcount++;
        end
        chk("post_rst_no_beats", 512'(vcount), 512'(0));
        chk("post_rst_ready", 512'(bus.mem_req_ready_o), 512'(1));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
